toy_bus_core_slv_node_pipe: RTL

Parametrised core-side slave node for the toy bus. It accepts core requests (LSU/fetch), decodes the address against a table of NUM_WIN windows to stamp a target id, and stamps a fixed source id. Requests pass through a registered 2-entry skid slice. Outstanding transactions are tracked and capped. Acks return combinationally from the network to the core.

---
 rtl/toy_bus_pkg.sv | 35 +++
 rtl/toy_bus_skid_buf.sv | 64 ++++++
 rtl/toy_bus_core_slv_node_pipe.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/toy_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : toy_bus_pkg
// Brief    : Shared widths, opcodes, default decode windows and request payload
// Revision : 1.0 - initial release
// ============================================================================
package toy_bus_pkg;

    localparam int TOY_BUS_ADDR_W = 32;
    localparam int TOY_BUS_DATA_W = 256;
    localparam int TOY_BUS_STRB_W = TOY_BUS_DATA_W / 8;
    localparam int TOY_BUS_SB_W   = 10;
    localparam int TOY_BUS_ID_W   = 4;

    localparam logic TOY_BUS_OP_RD = 1'b0;
    localparam logic TOY_BUS_OP_WR = 1'b1;

    localparam int TOY_BUS_NUM_WIN = 2;
    localparam logic [TOY_BUS_NUM_WIN*TOY_BUS_ADDR_W-1:0] TOY_BUS_WIN_BASE  = {32'hA000_0000, 32'h8000_0000};
    localparam logic [TOY_BUS_NUM_WIN*TOY_BUS_ADDR_W-1:0] TOY_BUS_WIN_LIMIT = {32'hC000_0000, 32'hA000_0000};
    localparam logic [TOY_BUS_NUM_WIN*TOY_BUS_ID_W-1:0]   TOY_BUS_WIN_TGT   = {4'd3, 4'd2};
    localparam int TOY_BUS_DFLT_TGT = 4;

    typedef struct packed {
        logic [TOY_BUS_ADDR_W-1:0] addr;
        logic [TOY_BUS_STRB_W-1:0] strb;
        logic [TOY_BUS_DATA_W-1:0] data;
        logic                      opcode;
        logic [TOY_BUS_SB_W-1:0]   sideband;
        logic [TOY_BUS_ID_W-1:0]   src_id;
        logic [TOY_BUS_ID_W-1:0]   tgt_id;
    } toy_bus_req_t;

endpackage
`default_nettype wire

// File: rtl/toy_bus_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : toy_bus_skid_buf
// Brief    : Generic 2-entry registered valid/ready slice (main + skid register)
// Revision : 1.0 - initial release
// ============================================================================
module toy_bus_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    logic         r_main_vld;
    logic         r_skid_vld;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         w_fire;
    logic         w_drain;

    assign in_rdy  = !r_skid_vld;
    assign w_fire  = in_vld && !r_skid_vld;
    assign w_drain = r_main_vld && out_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else if (w_drain) begin
            // skid is only ever occupied when main is, so it refills main first
            if (r_skid_vld) begin
                r_main     <= r_skid;
                r_skid_vld <= 1'b0;
            end else if (w_fire) begin
                r_main     <= in_data;
            end else begin
                r_main_vld <= 1'b0;
            end
        end else if (!r_main_vld) begin
            if (w_fire) begin
                r_main     <= in_data;
                r_main_vld <= 1'b1;
            end
        end else if (w_fire) begin
            r_skid     <= in_data;
            r_skid_vld <= 1'b1;
        end
    end

    assign out_vld  = r_main_vld;
    assign out_data = r_main;
    assign occ      = {r_skid_vld, r_main_vld & ~r_skid_vld};

endmodule
`default_nettype wire

// File: rtl/toy_bus_core_slv_node_pipe.sv
`default_nettype none
// ============================================================================
// Module   : toy_bus_core_slv_node_pipe
// Brief    : Core-side slave node: window decode, registered skid slice,
//            outstanding cap, combinational ack return.
//            Optional macro TOY_BUS_CORE_SLV_TGT_CHK_EN: drop and flag acks
//            whose target id is not SRC_ID.
// Revision : 1.0 - initial release
// ============================================================================
module toy_bus_core_slv_node_pipe
    import toy_bus_pkg::*;
#(
    parameter int ADDR_W     = TOY_BUS_ADDR_W,
    parameter int DATA_W     = TOY_BUS_DATA_W,
    parameter int SB_W       = TOY_BUS_SB_W,
    parameter int ID_W       = TOY_BUS_ID_W,
    parameter int SRC_ID     = 1,
    parameter int NUM_WIN    = TOY_BUS_NUM_WIN,
    parameter logic [NUM_WIN*ADDR_W-1:0] WIN_BASE  = TOY_BUS_WIN_BASE,
    parameter logic [NUM_WIN*ADDR_W-1:0] WIN_LIMIT = TOY_BUS_WIN_LIMIT,
    parameter logic [NUM_WIN*ID_W-1:0]   WIN_TGT   = TOY_BUS_WIN_TGT,
    parameter int DFLT_TGT   = TOY_BUS_DFLT_TGT,
    parameter int MAX_OUTSTD = 8,
    localparam int STRB_W    = DATA_W / 8,
    localparam int CNT_W     = $clog2(MAX_OUTSTD + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_req_vld,
    output logic              in0_req_rdy,
    input  logic [ADDR_W-1:0] in0_req_addr,
    input  logic [DATA_W-1:0] in0_req_data,
    input  logic [STRB_W-1:0] in0_req_strb,
    input  logic              in0_req_opcode,
    input  logic [SB_W-1:0]   in0_req_sideband,
    output logic              in0_ack_vld,
    input  logic              in0_ack_rdy,
    output logic [DATA_W-1:0] in0_ack_data,
    output logic [SB_W-1:0]   in0_ack_sideband,
    output logic              out0_req_vld,
    input  logic              out0_req_rdy,
    output logic [ADDR_W-1:0] out0_req_addr,
    output logic [STRB_W-1:0] out0_req_strb,
    output logic [DATA_W-1:0] out0_req_data,
    output logic              out0_req_opcode,
    output logic [SB_W-1:0]   out0_req_sideband,
    output logic [ID_W-1:0]   out0_req_src_id,
    output logic [ID_W-1:0]   out0_req_tgt_id,
    input  logic              out0_ack_vld,
    output logic              out0_ack_rdy,
    input  logic              out0_ack_opcode,
    input  logic [DATA_W-1:0] out0_ack_data,
    input  logic [SB_W-1:0]   out0_ack_sideband,
    input  logic [ID_W-1:0]   out0_ack_src_id,
    input  logic [ID_W-1:0]   out0_ack_tgt_id,
    output logic [CNT_W-1:0]  outstd_cnt,
    output logic              err_tgt
);

    localparam int PLD_W = $bits(toy_bus_req_t);

    toy_bus_req_t     w_in_pld;
    toy_bus_req_t     w_out_pld;
    logic [ID_W-1:0]  w_tgt;
    logic [1:0]       w_occ;
    logic             w_buf_in_rdy;
    logic             w_admit;
    logic             w_req_hs;
    logic             w_ack_hs;
    logic [CNT_W-1:0] r_cnt;

    // Reverse scan so the lowest matching window index has the final word
    always_comb begin
        w_tgt = ID_W'(DFLT_TGT);
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if ((in0_req_addr >= WIN_BASE[i*ADDR_W +: ADDR_W]) &&
                (in0_req_addr <  WIN_LIMIT[i*ADDR_W +: ADDR_W])) begin
                w_tgt = WIN_TGT[i*ID_W +: ID_W];
            end
        end
    end

    always_comb begin
        w_in_pld          = '0;
        w_in_pld.addr     = in0_req_addr;
        w_in_pld.strb     = in0_req_strb;
        w_in_pld.data     = in0_req_data;
        w_in_pld.opcode   = in0_req_opcode;
        w_in_pld.sideband = in0_req_sideband;
        w_in_pld.src_id   = ID_W'(SRC_ID);
        w_in_pld.tgt_id   = w_tgt;
    end

    // Buffered entries are counted against the cap before they reach the network
    assign w_admit = !rst &&
                     (({2'b00, r_cnt} + (CNT_W+2)'(w_occ)) < (CNT_W+2)'(MAX_OUTSTD));
    assign in0_req_rdy = w_buf_in_rdy && w_admit;

    toy_bus_skid_buf #(
        .W (PLD_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in0_req_vld && w_admit),
        .in_rdy   (w_buf_in_rdy),
        .in_data  (w_in_pld),
        .out_vld  (out0_req_vld),
        .out_rdy  (out0_req_rdy),
        .out_data (w_out_pld),
        .occ      (w_occ)
    );

    assign out0_req_addr     = w_out_pld.addr;
    assign out0_req_strb     = w_out_pld.strb;
    assign out0_req_data     = w_out_pld.data;
    assign out0_req_opcode   = w_out_pld.opcode;
    assign out0_req_sideband = w_out_pld.sideband;
    assign out0_req_src_id   = w_out_pld.src_id;
    assign out0_req_tgt_id   = w_out_pld.tgt_id;

    assign in0_ack_data     = out0_ack_data;
    assign in0_ack_sideband = out0_ack_sideband;

`ifdef TOY_BUS_CORE_SLV_TGT_CHK_EN
    logic w_bad_ack;
    logic r_err;
    logic w_unused_ok;

    assign w_bad_ack    = out0_ack_vld && (out0_ack_tgt_id != ID_W'(SRC_ID));
    assign in0_ack_vld  = out0_ack_vld && !w_bad_ack;
    assign out0_ack_rdy = in0_ack_rdy || w_bad_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_bad_ack) begin
            r_err <= 1'b1;
        end
    end

    assign err_tgt     = r_err;
    assign w_unused_ok = ^{out0_ack_opcode, out0_ack_src_id, TOY_BUS_OP_RD, TOY_BUS_OP_WR};
`else
    logic w_unused_ok;

    assign in0_ack_vld  = out0_ack_vld;
    assign out0_ack_rdy = in0_ack_rdy;
    assign err_tgt      = 1'b0;
    assign w_unused_ok  = ^{out0_ack_opcode, out0_ack_src_id, out0_ack_tgt_id,
                            TOY_BUS_OP_RD, TOY_BUS_OP_WR};
`endif

    assign w_req_hs = out0_req_vld && out0_req_rdy;
    assign w_ack_hs = in0_ack_vld && in0_ack_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_req_hs && !w_ack_hs) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_ack_hs && !w_req_hs && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign outstd_cnt = r_cnt;

    a_ack_underflow : assert property (@(posedge clk) disable iff (rst)
        !(w_ack_hs && !w_req_hs && (r_cnt == '0)));

endmodule
`default_nettype wire
